inv_key_expansion: RTL
======================

INV_KEY_EXPANSION -- requirements
Module: inv_key_expansion

Interface
REQ-001 Parameters: none; AES-128 only, 10 rounds fixed.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 RST  in  1  asynchronous active-low reset.
REQ-005 start_in  in  1  request; sampled only in IDLE.
REQ-006 key0_in..key3_in  in  32 each  seed key words; key0 = first column; bits [31:24] = first byte.
REQ-007 key0_out..key3_out  out  32 each  current round key, same word/byte order.
REQ-008 round_out  out  4  index of the round key on key*_out (10 down to 0).
REQ-009 valid_out  out  1  key*_out/round_out valid this cycle.
REQ-010 done_out  out  1  high only in the cycle round_out = 0 is valid.
REQ-011 state_out  out  2  FSM state: IDLE=0, DERIVE=1, RUN=2.

Function
REQ-012 The block SHALL emit AES-128 round keys in reverse order (10..0) for on-the-fly decryption, one key per cycle.
REQ-013 Inverse step from round r to r-1: k3'=w3^w2; k2'=w2^w1; k1'=w1^w0; k0'=w0^SubWord(RotWord(k3'))^Rcon[r].
REQ-014 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36 in byte [31:24]; other bytes zero.
REQ-015 IDLE + start_in=1 at an edge SHALL, without the macro, load key*_in into the working registers, set round to 10, and enter RUN.
REQ-016 In RUN, key*_out = working registers, round_out = round counter, valid_out = 1.
REQ-017 Each RUN edge with round > 0 SHALL apply REQ-013 and decrement round; the edge with round = 0 SHALL return to IDLE.
REQ-018 Output timing: exactly 11 consecutive valid cycles, starting the cycle after start is sampled, with rounds 10,9,...,0.
REQ-019 In IDLE and DERIVE, key*_out, round_out, valid_out and done_out SHALL be 0.
REQ-020 start_in SHALL be ignored outside IDLE, and key*_in SHALL be ignored except on the load edge.
REQ-021 start_in held high through the final RUN cycle SHALL cause a restart, not a merge: IDLE for one cycle, then a new sequence.
REQ-022 state_out encoding 3 SHALL never occur; if reached, the next state SHALL be IDLE.

Reset
REQ-023 RST=0 SHALL immediately force IDLE, zero the working registers and round counter, and drive all outputs to 0, including mid-sequence.
REQ-024 After RST release, the first start_in is accepted at the first rising edge.

Configuration
REQ-025 Macro INVKEY_DERIVE_LAST_EN.
REQ-026 Defined: key*_in is the cipher (round-0) key. IDLE+start SHALL enter DERIVE with the registers loaded and round = 0.
REQ-027 Defined, continued: DERIVE applies the forward step with Rcon[round+1] for 10 edges and reaches round = 10, then enters RUN.
REQ-028 Defined, timing: the first valid output SHALL appear 11 cycles after the start edge.
REQ-029 Undefined: key*_in is the round-10 key, DERIVE is never entered, and no forward-step logic is present.

Structure
REQ-030 A shared package SHALL hold the state encodings, Rcon table, AES_ROUNDS=10, and the word type.
REQ-031 Sub-module inv_key_round: combinational single inverse step (4 words + round in, 4 words out) instantiating the existing word S-box.
REQ-032 With the macro, the forward step SHALL reuse the same S-box path; only one S-box instance is permitted.

Verification
REQ-033 No macro; key*_in = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, start -> round 10 = input, round 9 = ac7766f3 19fadc21 28d12941 575c006e, round 0 = 2b7e1516 28aed2a6 abf71588 09cf4f3c with done_out=1.
REQ-034 Macro defined; key*_in = 2b7e1516 28aed2a6 abf71588 09cf4f3c -> DERIVE for 10 cycles, then the same 11 keys as REQ-033.
REQ-035 Pulse RST low while round_out=5 -> all outputs 0 at once, state_out=0; a new start gives a full correct sequence.
REQ-036 Toggle start_in and key*_in during RUN -> output sequence unchanged, with exactly 11 valid cycles.
REQ-037 start_in held high continuously -> sequences separated by exactly one IDLE cycle, each with round_out 10..0.
REQ-038 Random keys (≥1000) checked against a forward-expansion model -> reverse outputs match for all rounds, in both macro builds.

Source files
------------

// File: rtl/inv_key_expansion_pkg.sv
// -----------------------------------------------------------------------------
// inv_key_expansion_pkg
// Shared definitions for the AES-128 reverse round-key generator:
//   - AES_ROUNDS       : number of AES-128 rounds (10)
//   - aes_word_t       : one 32-bit key column, bits [31:24] = first byte
//   - round_t          : round index type (0..10)
//   - state_t          : FSM encoding IDLE=0, DERIVE=1, RUN=2
//   - RCON_TABLE       : round constants, index 1..10 (index 0 unused)
//   - rcon_word()      : round constant placed in the first byte of a word
//   - rot_word()       : AES RotWord (cyclic left rotate by one byte)
// -----------------------------------------------------------------------------
package inv_key_expansion_pkg;

  localparam int AES_ROUNDS = 10;

  typedef logic [31:0] aes_word_t;
  typedef logic [3:0]  round_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DERIVE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  localparam logic [7:0] RCON_TABLE [0:AES_ROUNDS] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Rcon[r] in byte [31:24]; indices outside 1..10 yield zero.
  function automatic aes_word_t rcon_word(input round_t r);
    aes_word_t w;
    w = '0;
    if ((r >= 4'd1) && (r <= 4'(AES_ROUNDS))) begin
      w = {RCON_TABLE[r], 24'h000000};
    end
    return w;
  endfunction

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/inv_key_expansion_round.sv
// -----------------------------------------------------------------------------
// aes_sbox_word
// Four parallel AES S-box byte lookups on one 32-bit word (SubWord).
//   word_in  : input word
//   word_out : SubWord(word_in)
//
// inv_key_round
// Combinational single key-schedule step for AES-128.
//   w0_in..w3_in   : current round key columns (w0 = first column)
//   round_in       : index r of the current round key
//   fwd_in         : (only with INVKEY_DERIVE_LAST_EN) 1 = forward step r->r+1
//   w0_out..w3_out : round key r-1 (inverse) or r+1 (forward)
// Inverse step: k3=w3^w2, k2=w2^w1, k1=w1^w0, k0=w0^SubWord(RotWord(k3))^Rcon[r].
// Forward step (macro INVKEY_DERIVE_LAST_EN): standard expansion with Rcon[r+1].
// Both directions share a single S-box instance through an input mux.
// -----------------------------------------------------------------------------
module aes_sbox_word
  import inv_key_expansion_pkg::*;
(
  input  aes_word_t word_in,
  output aes_word_t word_out
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign word_out[8*gi +: 8] = SBOX[word_in[8*gi +: 8]];
  end

endmodule

module inv_key_round
  import inv_key_expansion_pkg::*;
(
  input  aes_word_t w0_in,
  input  aes_word_t w1_in,
  input  aes_word_t w2_in,
  input  aes_word_t w3_in,
  input  round_t    round_in,
`ifdef INVKEY_DERIVE_LAST_EN
  input  logic      fwd_in,
`endif
  output aes_word_t w0_out,
  output aes_word_t w1_out,
  output aes_word_t w2_out,
  output aes_word_t w3_out
);

  aes_word_t inv0, inv1, inv2, inv3;
  aes_word_t sbox_in, sbox_out;

  // Previous-round columns 1..3 fall straight out of the XOR chain; column 0
  // needs the recovered k3' to undo the SubWord/RotWord term.
  assign inv3 = w3_in ^ w2_in;
  assign inv2 = w2_in ^ w1_in;
  assign inv1 = w1_in ^ w0_in;
  assign inv0 = w0_in ^ sbox_out ^ rcon_word(round_in);

`ifdef INVKEY_DERIVE_LAST_EN
  aes_word_t fwd0, fwd1, fwd2, fwd3;

  // Forward direction feeds the current last column into the shared S-box.
  assign sbox_in = fwd_in ? rot_word(w3_in) : rot_word(inv3);

  assign fwd0 = w0_in ^ sbox_out ^ rcon_word(round_t'(round_in + 4'd1));
  assign fwd1 = w1_in ^ fwd0;
  assign fwd2 = w2_in ^ fwd1;
  assign fwd3 = w3_in ^ fwd2;

  assign w0_out = fwd_in ? fwd0 : inv0;
  assign w1_out = fwd_in ? fwd1 : inv1;
  assign w2_out = fwd_in ? fwd2 : inv2;
  assign w3_out = fwd_in ? fwd3 : inv3;
`else
  assign sbox_in = rot_word(inv3);

  assign w0_out = inv0;
  assign w1_out = inv1;
  assign w2_out = inv2;
  assign w3_out = inv3;
`endif

  aes_sbox_word u_sbox (
    .word_in  (sbox_in),
    .word_out (sbox_out)
  );

endmodule

// File: rtl/inv_key_expansion.sv
// -----------------------------------------------------------------------------
// inv_key_expansion
// Emits the AES-128 round keys in reverse order (10 down to 0), one per cycle,
// for on-the-fly decryption.
//
// Ports:
//   CLK              : rising-edge clock
//   RST              : asynchronous active-low reset
//   start_in         : start request, only looked at in IDLE
//   key0_in..key3_in : seed key (key0 = first column, [31:24] = first byte)
//   key0_out..3_out  : current round key (zero outside RUN)
//   round_out        : index of the key on key*_out (zero outside RUN)
//   valid_out        : key*_out / round_out valid
//   done_out         : high in the cycle round 0 is presented
//   state_out        : FSM state, IDLE=0 DERIVE=1 RUN=2
//
// Build option INVKEY_DERIVE_LAST_EN:
//   undefined : key*_in is the round-10 key; start goes straight to RUN.
//   defined   : key*_in is the cipher key; ten DERIVE cycles run the forward
//               schedule up to round 10 before RUN begins.
// -----------------------------------------------------------------------------
module inv_key_expansion
  import inv_key_expansion_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        start_in,
  input  logic [31:0] key0_in,
  input  logic [31:0] key1_in,
  input  logic [31:0] key2_in,
  input  logic [31:0] key3_in,
  output logic [31:0] key0_out,
  output logic [31:0] key1_out,
  output logic [31:0] key2_out,
  output logic [31:0] key3_out,
  output logic [3:0]  round_out,
  output logic        valid_out,
  output logic        done_out,
  output logic [1:0]  state_out
);

  state_t    state_q, state_d;
  round_t    round_q, round_d;
  aes_word_t w0_q, w1_q, w2_q, w3_q;
  aes_word_t w0_d, w1_d, w2_d, w3_d;
  aes_word_t step0, step1, step2, step3;
  logic      run_active;

  inv_key_round u_round (
    .w0_in    (w0_q),
    .w1_in    (w1_q),
    .w2_in    (w2_q),
    .w3_in    (w3_q),
    .round_in (round_q),
`ifdef INVKEY_DERIVE_LAST_EN
    .fwd_in   (state_q == ST_DERIVE),
`endif
    .w0_out   (step0),
    .w1_out   (step1),
    .w2_out   (step2),
    .w3_out   (step3)
  );

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    w3_d    = w3_q;

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          w0_d = key0_in;
          w1_d = key1_in;
          w2_d = key2_in;
          w3_d = key3_in;
`ifdef INVKEY_DERIVE_LAST_EN
          round_d = '0;
          state_d = ST_DERIVE;
`else
          round_d = round_t'(AES_ROUNDS);
          state_d = ST_RUN;
`endif
        end
      end

      ST_DERIVE: begin
`ifdef INVKEY_DERIVE_LAST_EN
        w0_d    = step0;
        w1_d    = step1;
        w2_d    = step2;
        w3_d    = step3;
        round_d = round_q + 4'd1;
        // The edge that produces round 10 also hands over to RUN.
        if (round_q >= round_t'(AES_ROUNDS - 1)) begin
          state_d = ST_RUN;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      ST_RUN: begin
        if (round_q != 4'd0) begin
          w0_d    = step0;
          w1_d    = step1;
          w2_d    = step2;
          w3_d    = step3;
          round_d = round_q - 4'd1;
        end else begin
          // Always pass through IDLE so a held start_in restarts cleanly.
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      w3_q    <= w3_d;
    end
  end

  // Outputs are masked by state so IDLE/DERIVE (and reset) present zeros.
  assign run_active = (state_q == ST_RUN);
  assign key0_out   = run_active ? w0_q : '0;
  assign key1_out   = run_active ? w1_q : '0;
  assign key2_out   = run_active ? w2_q : '0;
  assign key3_out   = run_active ? w3_q : '0;
  assign round_out  = run_active ? round_q : '0;
  assign valid_out  = run_active;
  assign done_out   = run_active && (round_q == 4'd0);
  assign state_out  = state_q;

endmodule
